// File: rtl/video_arith_arb.sv
// rtl/video_arith_arb.sv - shared 12x12 shift/add multiplier and 24/12 restoring divider
// behind a round-robin arbiter for up to four requesters.
module video_arith_arb #(
  parameter int NREQ = 2
) (
  input  logic                 CLK_VIDEO,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [24*NREQ-1:0]   arg_a,
  input  logic [12*NREQ-1:0]   arg_b,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic [NREQ-1:0]      done,
  output logic [23:0]          res
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t            state, state_n;
  logic [3:0]        req4, op4;
  logic [23:0]       a4 [4];
  logic [11:0]       b4 [4];
  logic [1:0]        ptr, pick, cand;
  logic [NREQ-1:0]   win;
  logic [4:0]        cnt;
  logic [23:0]       ra, acc, acc_n, q_n;
  logic [11:0]       rb;
  logic [12:0]       rem, rem_n;
  logic [13:0]       trial;
  logic              ge;

  // Lanes beyond NREQ read as idle so the arbiter can always work on 4 slots.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    if (i < NREQ) begin : g_on
      assign req4[i] = req[i];
      assign op4[i]  = op[i];
      assign a4[i]   = arg_a[24*i +: 24];
      assign b4[i]   = arg_b[12*i +: 12];
    end else begin : g_off
      assign req4[i] = 1'b0;
      assign op4[i]  = 1'b0;
      assign a4[i]   = '0;
      assign b4[i]   = '0;
    end
  end

  // Walk from farthest to nearest so the first set bit after ptr wins.
  always_comb begin
    pick = ptr;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = 2'((int'(ptr) + k) % NREQ);
      if (req4[cand]) pick = cand;
    end
  end

  always_comb begin
    acc_n = rb[0] ? acc + ra : acc;
    trial = {rem, ra[23]};
    ge    = trial >= {2'b00, rb};
    rem_n = ge ? 13'(trial - {2'b00, rb}) : 13'(trial);
    q_n   = {ra[22:0], ge};
  end

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    gnt     = '0;
    done    = '0;
    busy    = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (|req4) state_n = op4[pick] ? DIV : MUL;
      end
      MUL: begin
        gnt = win;
        if (cnt == 5'd11) state_n = FIN;
      end
      DIV: begin
        gnt = win;
        if (cnt == 5'd23) state_n = FIN;
      end
      FIN: begin
        gnt     = win;
        done    = win;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // res is loaded on the last iteration edge so it is valid during the done cycle.
  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      res <= '0;
      cnt <= '0;
      ptr <= 2'(NREQ - 1);
      win <= '0;
      ra  <= '0;
      rb  <= '0;
      acc <= '0;
      rem <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req4) begin
            win <= NREQ'(4'b0001 << pick);
            ptr <= pick;
            cnt <= '0;
            ra  <= op4[pick] ? a4[pick] : {12'd0, a4[pick][11:0]};
            rb  <= b4[pick];
            acc <= '0;
            rem <= '0;
          end
        end
        MUL: begin
          acc <= acc_n;
          ra  <= {ra[22:0], 1'b0};
          rb  <= {1'b0, rb[11:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd11) res <= acc_n;
        end
        DIV: begin
          ra  <= q_n;
          rem <= rem_n;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd23) res <= (rb == 12'd0) ? 24'hFFFFFF : q_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_video_arith_arb.sv
// tb/tb_video_arith_arb.sv - directed self-checking bench for video_arith_arb.
module tb_video_arith_arb;

  localparam int NREQ = 2;

  logic                CLK_VIDEO = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req, op, gnt, done;
  logic [24*NREQ-1:0]  arg_a;
  logic [12*NREQ-1:0]  arg_b;
  logic                busy;
  logic [23:0]         res;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  video_arith_arb #(.NREQ(NREQ)) dut (
    .CLK_VIDEO(CLK_VIDEO),
    .reset(reset),
    .req(req),
    .op(op),
    .arg_a(arg_a),
    .arg_b(arg_b),
    .gnt(gnt),
    .busy(busy),
    .done(done),
    .res(res)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every cycle: gnt never multi-hot, done never without the matching gnt.
  task automatic tick();
    @(posedge CLK_VIDEO);
    #1;
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("done_has_gnt", 32'(done & ~gnt), 32'd0);
  endtask

  task automatic post(input bit lane, input logic o, input logic [23:0] a, input logic [11:0] b);
    if (lane == 1'b0) begin
      op[0] = o; arg_a[23:0] = a; arg_b[11:0] = b; req[0] = 1'b1;
    end else begin
      op[1] = o; arg_a[47:24] = a; arg_b[23:12] = b; req[1] = 1'b1;
    end
  endtask

  initial begin
    logic [NREQ-1:0] which;
    int budget;
    logic saw_done;

    req = '0; op = '0; arg_a = '0; arg_b = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    reset = 1'b0;
    tick();

    // single multiply 100*7 on requester 0
    post(1'b0, 1'b0, 24'd100, 12'd7);
    tick();
    chk("mul_gnt", 32'(gnt), 32'd1);
    chk("mul_busy", 32'(busy), 32'd1);
    repeat (11) tick();
    chk("mul_done_early", 32'(done), 32'd0);
    tick();
    chk("mul_done", 32'(done), 32'd1);
    chk("mul_res", 32'(res), 32'd700);
    req[0] = 1'b0;
    tick();
    chk("mul_done_pulse", 32'(done), 32'd0);
    chk("mul_idle_gnt", 32'(gnt), 32'd0);
    chk("mul_idle_busy", 32'(busy), 32'd0);
    chk("mul_res_hold", 32'(res), 32'd700);

    // single divide 1080/240 on requester 1
    post(1'b1, 1'b1, 24'd1080, 12'd240);
    tick();
    chk("div_gnt", 32'(gnt), 32'd2);
    repeat (23) tick();
    chk("div_done_early", 32'(done), 32'd0);
    tick();
    chk("div_done", 32'(done), 32'd2);
    chk("div_res", 32'(res), 32'd4);
    req[1] = 1'b0;
    tick();

    // divide by zero
    post(1'b0, 1'b1, 24'h123456, 12'd0);
    repeat (24) tick();
    chk("dz_done_early", 32'(done), 32'd0);
    tick();
    chk("dz_done", 32'(done), 32'd1);
    chk("dz_res", 32'(res), 32'h00FFFFFF);
    req[0] = 1'b0;
    tick();

    // widest multiply
    post(1'b1, 1'b0, 24'd4095, 12'd4095);
    repeat (13) tick();
    chk("mulmax_done", 32'(done), 32'd2);
    chk("mulmax_res", 32'(res), 32'd16769025);
    req[1] = 1'b0;
    tick();

    // contention: ptr last pointed at 1, so service order is 0,1,0,1
    post(1'b0, 1'b0, 24'd3, 12'd5);
    post(1'b1, 1'b0, 24'd6, 12'd7);
    for (int n = 0; n < 4; n++) begin
      budget = 0;
      do begin
        tick();
        budget++;
      end while (done == '0 && budget < 40);
      chk("cont_order", 32'(done), (n % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_res", 32'(res), (n % 2 == 0) ? 32'd15 : 32'd42);
      which = done;
      req = req & ~which;
      tick();
      if (n < 3) req = req | which;
    end
    req = '0;
    tick();

    // operands and req change mid-multiply must not disturb it
    post(1'b0, 1'b0, 24'd9, 12'd9);
    repeat (5) tick();
    arg_a[23:0] = 24'd100;
    arg_b[11:0] = 12'd50;
    req[0] = 1'b0;
    repeat (8) tick();
    chk("opchg_done", 32'(done), 32'd1);
    chk("opchg_res", 32'(res), 32'd81);
    tick();

    // reset in the middle of a divide
    post(1'b1, 1'b1, 24'd1000, 12'd7);
    repeat (10) tick();
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_gnt", 32'(gnt), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_res", 32'(res), 32'd0);
    req[1] = 1'b0;
    tick();
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (30) begin
      tick();
      saw_done = saw_done | (|done);
    end
    chk("rstmid_no_done", 32'(saw_done), 32'd0);
    post(1'b1, 1'b1, 24'd1000, 12'd7);
    repeat (25) tick();
    chk("rstmid_new_done", 32'(done), 32'd2);
    chk("rstmid_new_res", 32'(res), 32'd142);
    req[1] = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
